// File: rtl/dma_csr_status_regs_if.sv
// Bus bundle for the DMA CSR block: status-update req/ack channel plus Avalon-MM slave port.
// The master modport is the host/upstream side; the slave modport is the CSR block.
interface dma_csr_status_regs_if;
    logic [31:0] csr_status_update_i;
    logic [3:0]  csr_status_update_be_i;
    logic        csr_status_update_rq_i;
    logic        csr_status_update_ack_o;
    logic [1:0]  avs_address_i;
    logic        avs_read_i;
    logic        avs_write_i;
    logic [31:0] avs_writedata_i;
    logic [3:0]  avs_byteenable_i;
    logic [31:0] avs_readdata_o;
    logic        avs_readdatavalid_o;

    modport master (
        output csr_status_update_i, csr_status_update_be_i, csr_status_update_rq_i,
        output avs_address_i, avs_read_i, avs_write_i, avs_writedata_i, avs_byteenable_i,
        input  csr_status_update_ack_o, avs_readdata_o, avs_readdatavalid_o
    );

    modport slave (
        input  csr_status_update_i, csr_status_update_be_i, csr_status_update_rq_i,
        input  avs_address_i, avs_read_i, avs_write_i, avs_writedata_i, avs_byteenable_i,
        output csr_status_update_ack_o, avs_readdata_o, avs_readdatavalid_o
    );
endinterface

// File: rtl/dma_csr_status_regs.sv
// DMA STATUS/CONTROL register block with req/ack status-update merge and level interrupt.
// Optional interrupt coalescing is enabled by defining DMA_CSR_IRQ_COALESCE_EN.
module dma_csr_status_regs #(
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000,
    parameter int          CNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    dma_csr_status_regs_if.slave    bus,
    output logic [31:0]             csr_control_o,
    output logic                    dma_interrupt_rq_o
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACK = 2'd1, ST_HOLD = 2'd2} state_e;

    state_e             state_q, state_d;
    logic               ack_q, ack_d;
    logic               busy_q, busy_d, irq_q, irq_d, err_q, err_d;
    logic [7:0]         code_q, code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        ctrl_q, ctrl_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               rvalid_q, rvalid_d;
    logic               merge_s, event_s, irq_set_s, wr_status_s, wr_ctrl_s;
    logic [15:0]        cnt_ext_s;
    logic [31:0]        status_s, irqcnt_s;
    logic               unused_s;

    assign merge_s     = (state_q == ST_ACK);
    assign event_s     = merge_s & bus.csr_status_update_be_i[0] & bus.csr_status_update_i[1];
    assign wr_status_s = bus.avs_write_i & (bus.avs_address_i == 2'd0);
    assign wr_ctrl_s   = bus.avs_write_i & (bus.avs_address_i == 2'd1);
    assign unused_s    = ^{bus.csr_status_update_i[31:16], bus.csr_status_update_be_i[3]};

    // Update handshake FSM: one ack per request, rq must drop before the next one
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.csr_status_update_rq_i) state_d = ST_ACK;
                else                            state_d = ST_IDLE;
            end
            ST_ACK:  state_d = ST_HOLD;
            ST_HOLD: begin
                if (!bus.csr_status_update_rq_i) state_d = ST_IDLE;
                else                             state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
        ack_d = (state_d == ST_ACK);
    end

`ifdef DMA_CSR_IRQ_COALESCE_EN
    logic [15:0] coal_q, coal_d;
    logic [16:0] coal_inc_s;

    // Coalescing counter: raise irq_pending once the threshold of events is reached
    always_comb begin
        coal_inc_s = {1'b0, coal_q} + 17'd1;
        coal_d     = coal_q;
        irq_set_s  = 1'b0;
        if (event_s) begin
            if (coal_inc_s >= {1'b0, ctrl_q[31:16]}) begin
                irq_set_s = 1'b1;
                coal_d    = 16'h0000;
            end else begin
                coal_d    = coal_inc_s[15:0];
            end
        end else begin
            coal_d = coal_q;
        end
        if (wr_ctrl_s && (bus.avs_byteenable_i[2] || bus.avs_byteenable_i[3])) begin
            coal_d = 16'h0000;
        end else begin
            coal_d = coal_d;
        end
    end

    assign irqcnt_s = {16'h0000, coal_q};

    // Coalescing counter register
    always_ff @(posedge clk) begin
        if (!reset_n) coal_q <= 16'h0000;
        else          coal_q <= coal_d;
    end
`else
    assign irq_set_s = event_s;
    assign irqcnt_s  = 32'h0000_0000;
`endif

    // STATUS next state: host W1C first, then the update merge so a same-cycle set wins
    always_comb begin
        busy_d = busy_q;
        irq_d  = irq_q;
        err_d  = err_q;
        code_d = code_q;
        cnt_d  = cnt_q;
        if (wr_status_s && bus.avs_byteenable_i[0]) begin
            if (bus.avs_writedata_i[1]) irq_d = 1'b0; else irq_d = irq_q;
            if (bus.avs_writedata_i[2]) err_d = 1'b0; else err_d = err_q;
        end else begin
            irq_d = irq_q;
        end
        if (merge_s) begin
            if (bus.csr_status_update_be_i[0]) begin
                busy_d = bus.csr_status_update_i[0];
                if (bus.csr_status_update_i[2]) err_d = 1'b1; else err_d = err_d;
            end else begin
                busy_d = busy_q;
            end
            // Either byte 1 or byte 2 enabled refreshes the status code
            if (bus.csr_status_update_be_i[1] || bus.csr_status_update_be_i[2]) begin
                code_d = bus.csr_status_update_i[15:8];
            end else begin
                code_d = code_q;
            end
        end else begin
            code_d = code_q;
        end
        if (irq_set_s) irq_d = 1'b1; else irq_d = irq_d;
        if (event_s)   cnt_d = cnt_q + CNT_W'(1'b1); else cnt_d = cnt_q;
    end

    // CONTROL next state: byte-enabled host overwrite
    always_comb begin
        ctrl_d = ctrl_q;
        if (wr_ctrl_s) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.avs_byteenable_i[b]) ctrl_d[8*b +: 8] = bus.avs_writedata_i[8*b +: 8];
                else                         ctrl_d[8*b +: 8] = ctrl_q[8*b +: 8];
            end
        end else begin
            ctrl_d = ctrl_q;
        end
    end

    // Read path: a read colliding with a write is dropped
    always_comb begin
        cnt_ext_s              = 16'h0000;
        cnt_ext_s[CNT_W-1:0]   = cnt_q;
        status_s               = {cnt_ext_s, code_q, 5'b00000, err_q, irq_q, busy_q};
        rvalid_d               = bus.avs_read_i & ~bus.avs_write_i;
        rdata_d                = 32'h0000_0000;
        if (rvalid_d) begin
            case (bus.avs_address_i)
                2'd0:    rdata_d = status_s;
                2'd1:    rdata_d = ctrl_q;
                2'd2:    rdata_d = irqcnt_s;
                default: rdata_d = 32'h0000_0000;
            endcase
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
            irq_q    <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= 8'h00;
            cnt_q    <= '0;
            ctrl_q   <= CTRL_RESET;
            rdata_q  <= 32'h0000_0000;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            irq_q    <= irq_d;
            err_q    <= err_d;
            code_q   <= code_d;
            cnt_q    <= cnt_d;
            ctrl_q   <= ctrl_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign bus.csr_status_update_ack_o = ack_q;
    assign bus.avs_readdata_o          = rdata_q;
    assign bus.avs_readdatavalid_o     = rvalid_q;
    assign csr_control_o               = ctrl_q;
    assign dma_interrupt_rq_o          = irq_q & ctrl_q[4];
endmodule

// File: tb/tb_dma_csr_status_regs.sv
// Directed, table-driven bench for dma_csr_status_regs (built with CNT_W=2 to reach counter wrap).
module tb_dma_csr_status_regs;
    localparam logic [31:0] CTRL_RST = 32'h0000_0100;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp_status;
    } upd_vec_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [1:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } host_vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] csr_control;
    logic        irq;
    int          n_cmp = 0;
    int          n_fail = 0;
    upd_vec_t    upd_tbl [9];
    host_vec_t   host_tbl [8];

    dma_csr_status_regs_if bus ();

    dma_csr_status_regs #(.CTRL_RESET(CTRL_RST), .CNT_W(2)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .bus                (bus.slave),
        .csr_control_o      (csr_control),
        .dma_interrupt_rq_o (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // All tasks start and end at a falling edge.
    task automatic host_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
        bus.avs_address_i = a; bus.avs_writedata_i = d; bus.avs_byteenable_i = be;
        bus.avs_write_i = 1'b1;
        @(negedge clk);
        bus.avs_write_i = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        bus.avs_address_i = a; bus.avs_read_i = 1'b1;
        @(negedge clk);
        bus.avs_read_i = 1'b0;
        chk({name, "_rdv"}, {31'd0, bus.avs_readdatavalid_o}, 32'd1);
        chk(name, bus.avs_readdata_o, exp);
        @(negedge clk);
        chk({name, "_rdv_end"}, {31'd0, bus.avs_readdatavalid_o}, 32'd0);
    endtask

    task automatic do_update(input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        bus.csr_status_update_i = d; bus.csr_status_update_be_i = be;
        bus.csr_status_update_rq_i = 1'b1;
        while (!bus.csr_status_update_ack_o && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("upd_ack", {31'd0, bus.csr_status_update_ack_o}, 32'd1);
        @(negedge clk);
        bus.csr_status_update_rq_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acks;
        int ack_cyc;

        upd_tbl[0] = '{32'h0000_0002, 4'b0001, 32'h0000_AB02};
        upd_tbl[1] = '{32'h0000_0002, 4'b0001, 32'h0001_AB02};
        upd_tbl[2] = '{32'h0000_1205, 4'b0011, 32'h0001_1207};
        upd_tbl[3] = '{32'h0000_3402, 4'b0010, 32'h0001_3407};
        upd_tbl[4] = '{32'hFFFF_FF00, 4'b1000, 32'h0001_3407};
        upd_tbl[5] = '{32'h0000_0003, 4'b0001, 32'h0002_3407};
        upd_tbl[6] = '{32'h0000_0002, 4'b0001, 32'h0003_3406};
        upd_tbl[7] = '{32'h0000_0002, 4'b0001, 32'h0000_3406};
        upd_tbl[8] = '{32'h0000_56F9, 4'b0011, 32'h0000_5607};

        host_tbl[0] = '{2'd0, 32'hFFFF_FFFF, 4'b1110, 2'd0, 32'h0000_5607, 1'b1};
        host_tbl[1] = '{2'd0, 32'h0000_0004, 4'b0001, 2'd0, 32'h0000_5603, 1'b1};
        host_tbl[2] = '{2'd0, 32'h0000_00FE, 4'b0001, 2'd0, 32'h0000_5601, 1'b0};
        host_tbl[3] = '{2'd1, 32'hDEAD_BEEF, 4'b1111, 2'd1, 32'hDEAD_BEEF, 1'b0};
        host_tbl[4] = '{2'd1, 32'h1234_5678, 4'b0101, 2'd1, 32'hDE34_BE78, 1'b0};
        host_tbl[5] = '{2'd1, 32'h0000_0010, 4'b1111, 2'd1, 32'h0000_0010, 1'b0};
        host_tbl[6] = '{2'd2, 32'hFFFF_FFFF, 4'b1111, 2'd2, 32'h0000_0000, 1'b0};
        host_tbl[7] = '{2'd3, 32'hFFFF_FFFF, 4'b1111, 2'd3, 32'h0000_0000, 1'b0};

        // Reset held two cycles with a pending request
        reset_n = 1'b0;
        bus.csr_status_update_i = 32'h0; bus.csr_status_update_be_i = 4'h0;
        bus.csr_status_update_rq_i = 1'b1;
        bus.avs_address_i = 2'd0; bus.avs_read_i = 1'b0; bus.avs_write_i = 1'b0;
        bus.avs_writedata_i = 32'h0; bus.avs_byteenable_i = 4'h0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ack", {31'd0, bus.csr_status_update_ack_o}, 32'd0);
        chk("rst_rdv", {31'd0, bus.avs_readdatavalid_o}, 32'd0);
        chk("rst_rdata", bus.avs_readdata_o, 32'h0);
        chk("rst_ctrl", csr_control, CTRL_RST);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        bus.csr_status_update_rq_i = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        host_read(2'd0, 32'h0, "rst_status");

        // Request held 5 cycles yields exactly one ack, on cycle 2
        bus.csr_status_update_i = 32'h0000_AB03; bus.csr_status_update_be_i = 4'b0011;
        bus.csr_status_update_rq_i = 1'b1;
        acks = 0; ack_cyc = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (bus.csr_status_update_ack_o) begin
                acks++;
                ack_cyc = i + 1;
            end
        end
        bus.csr_status_update_rq_i = 1'b0;
        @(negedge clk);
        chk("hs_ack_count", acks, 32'd1);
        chk("hs_ack_cycle", ack_cyc, 32'd2);
        host_read(2'd0, 32'h0001_AB03, "hs_status");
        chk("hs_irq_masked", {31'd0, irq}, 32'd0);

        // IRQ rise on update, fall the cycle after W1C
        host_write(2'd0, 32'h2, 4'b0001);
        host_write(2'd1, 32'h10, 4'b1111);
        chk("irq_ctrl_follow", csr_control, 32'h10);
        chk("irq_cleared", {31'd0, irq}, 32'd0);
        do_update(32'h2, 4'b0001);
        chk("irq_set", {31'd0, irq}, 32'd1);
        host_write(2'd0, 32'h2, 4'b0001);
        chk("irq_w1c", {31'd0, irq}, 32'd0);

        // W1C colliding with the merge edge: the set wins
        bus.csr_status_update_i = 32'h2; bus.csr_status_update_be_i = 4'b0001;
        bus.csr_status_update_rq_i = 1'b1;
        @(negedge clk);
        chk("col_ack", {31'd0, bus.csr_status_update_ack_o}, 32'd1);
        bus.avs_address_i = 2'd0; bus.avs_writedata_i = 32'h2; bus.avs_byteenable_i = 4'b0001;
        bus.avs_write_i = 1'b1;
        @(negedge clk);
        bus.avs_write_i = 1'b0;
        bus.csr_status_update_rq_i = 1'b0;
        chk("col_irq", {31'd0, irq}, 32'd1);
        @(negedge clk);
        host_read(2'd0, 32'h0003_AB02, "col_status");

        // Merge rules and done-count wrap (the 5th qualifying update reads count 1)
        for (int i = 0; i < 9; i++) begin
            do_update(upd_tbl[i].data, upd_tbl[i].be);
            host_read(2'd0, upd_tbl[i].exp_status, $sformatf("upd%0d", i));
        end

        // Host register accesses
        for (int i = 0; i < 8; i++) begin
            host_write(host_tbl[i].addr, host_tbl[i].wdata, host_tbl[i].be);
            chk($sformatf("host%0d_irq", i), {31'd0, irq}, {31'd0, host_tbl[i].exp_irq});
            host_read(host_tbl[i].raddr, host_tbl[i].exp_rd, $sformatf("host%0d", i));
        end

        // Read and write in one cycle: write lands, no read data
        bus.avs_address_i = 2'd1; bus.avs_writedata_i = 32'h11; bus.avs_byteenable_i = 4'hF;
        bus.avs_read_i = 1'b1; bus.avs_write_i = 1'b1;
        @(negedge clk);
        bus.avs_read_i = 1'b0; bus.avs_write_i = 1'b0;
        chk("rw_rdv", {31'd0, bus.avs_readdatavalid_o}, 32'd0);
        chk("rw_ctrl", csr_control, 32'h11);
        host_write(2'd1, 32'h10, 4'hF);

`ifdef DMA_CSR_IRQ_COALESCE_EN
        // Coalescing: threshold 3 raises irq only on the third event
        host_write(2'd1, 32'h0003_0010, 4'hF);
        for (int k = 1; k <= 3; k++) begin
            do_update(32'h2, 4'b0001);
            chk($sformatf("coal%0d_irq", k), {31'd0, irq}, (k == 3) ? 32'd1 : 32'd0);
            host_read(2'd2, (k == 3) ? 32'd0 : k, $sformatf("coal%0d_cnt", k));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
